// File: rtl/boot_run_ctrl.sv
// Boot sequencer: streams a program image into memory, releases the core,
// then captures and supervises the first halt, reporting done or an error code.
module boot_run_ctrl #(
    parameter int unsigned LOAD_WORDS    = 256,
    parameter int unsigned SETTLE_CYCLES = 5,
    parameter int unsigned TIMEOUT       = 1000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [15:0]      src_data,
    output logic             src_ready,
    input  logic             core_mem_req,
    input  logic             core_mem_wr,
    input  logic [15:0]      core_mem_addr,
    input  logic [15:0]      core_mem_wdata,
    output logic             mem_en,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_wdata,
    output logic             core_rst,
    input  logic             core_halt,
    input  logic [15:0]      core_first_word,
    output logic             halted,
    output logic [15:0]      halt_word,
    output logic [CNT_W-1:0] halt_cycle,
    output logic             done,
    output logic [1:0]       err_code
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [15:0]      LAST_ADDR = 16'(LOAD_WORDS - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [SET_W-1:0] SETTLE_C  = SET_W'(SETTLE_CYCLES);

    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_DROP    = 2'd2;
    localparam logic [1:0] ERR_WORD    = 2'd3;

    typedef enum logic [2:0] {
        S_LOAD,
        S_RELEASE,
        S_RUN,
        S_SETTLE,
        S_DONE,
        S_ERROR
    } state_e;

    state_e           state_q;
    logic [15:0]      load_addr_q;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_d;
    logic [SET_W-1:0] settle_cnt_q;
    logic [SET_W-1:0] settle_cnt_d;
    logic             halted_q;
    logic [15:0]      halt_word_q;
    logic [CNT_W-1:0] halt_cycle_q;
    logic             done_q;
    logic [1:0]       err_code_q;
    logic             core_owns_mem;

    assign cycle_cnt_d  = cycle_cnt_q + CNT_W'(1);
    assign settle_cnt_d = settle_cnt_q + SET_W'(1);

    // Sequencer state and captured status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_LOAD;
            load_addr_q  <= 16'd0;
            cycle_cnt_q  <= '0;
            settle_cnt_q <= '0;
            halted_q     <= 1'b0;
            halt_word_q  <= 16'd0;
            halt_cycle_q <= '0;
            done_q       <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (src_valid) begin
                        load_addr_q <= load_addr_q + 16'd1;
                        if (load_addr_q == LAST_ADDR) begin
                            state_q <= S_RELEASE;
                        end
                    end
                end
                S_RELEASE: begin
                    cycle_cnt_q <= '0;
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    cycle_cnt_q <= cycle_cnt_d;
                    if (core_halt) begin
                        halted_q     <= 1'b1;
                        halt_word_q  <= core_first_word;
                        halt_cycle_q <= cycle_cnt_d;
                        settle_cnt_q <= '0;
                        state_q      <= S_SETTLE;
                    end else if (cycle_cnt_d > TIMEOUT_C) begin
                        err_code_q <= ERR_TIMEOUT;
                        state_q    <= S_ERROR;
                    end
                end
                S_SETTLE: begin
                    if (!core_halt) begin
                        err_code_q <= ERR_DROP;
                        state_q    <= S_ERROR;
                    end else if (core_first_word != halt_word_q) begin
                        err_code_q <= ERR_WORD;
                        state_q    <= S_ERROR;
                    end else begin
                        settle_cnt_q <= settle_cnt_d;
                        if (settle_cnt_d == SETTLE_C) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_DONE;
                end
                S_ERROR: begin
                    state_q <= S_ERROR;
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end

    assign core_owns_mem = (state_q == S_RUN) || (state_q == S_SETTLE) || (state_q == S_DONE);

    // Memory port mux: loader during LOAD, core once released, idle otherwise
    always_comb begin
        src_ready = 1'b0;
        core_rst  = 1'b1;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 16'd0;
        mem_wdata = 16'd0;
        if (state_q == S_LOAD) begin
            src_ready = 1'b1;
            mem_en    = src_valid;
            mem_wr    = src_valid;
            mem_addr  = load_addr_q;
            mem_wdata = src_data;
        end else if (core_owns_mem) begin
            core_rst  = 1'b0;
            mem_en    = core_mem_req;
            mem_wr    = core_mem_wr;
            mem_addr  = core_mem_addr;
            mem_wdata = core_mem_wdata;
        end
    end

    assign halted     = halted_q;
    assign halt_word  = halt_word_q;
    assign halt_cycle = halt_cycle_q;
    assign done       = done_q;
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_boot_run_ctrl.sv
// Scoreboard bench for boot_run_ctrl: stimulus queues expected memory traffic
// and final status; a negedge monitor pops and compares as the DUT presents them.
module tb_boot_run_ctrl;

    localparam int unsigned LW  = 4;
    localparam int unsigned SC  = 5;
    localparam int unsigned TO  = 40;
    localparam int unsigned CW  = 32;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } mem_t;

    typedef struct packed {
        logic          done;
        logic          crst;
        logic [1:0]    err;
        logic          halted;
        logic [15:0]   word;
        logic [CW-1:0] cyc;
    } st_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          src_valid = 1'b0;
    logic [15:0]   src_data = 16'd0;
    logic          src_ready;
    logic          core_mem_req = 1'b0;
    logic          core_mem_wr = 1'b0;
    logic [15:0]   core_mem_addr = 16'd0;
    logic [15:0]   core_mem_wdata = 16'd0;
    logic          mem_en, mem_wr;
    logic [15:0]   mem_addr, mem_wdata;
    logic          core_rst;
    logic          core_halt = 1'b0;
    logic [15:0]   core_first_word = 16'd0;
    logic          halted;
    logic [15:0]   halt_word;
    logic [CW-1:0] halt_cycle;
    logic          done;
    logic [1:0]    err_code;

    int   assertions = 0;
    int   failures   = 0;
    mem_t mem_q[$];
    st_t  st_q[$];
    bit   term_seen = 1'b0;

    boot_run_ctrl #(
        .LOAD_WORDS(LW), .SETTLE_CYCLES(SC), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .core_mem_req(core_mem_req), .core_mem_wr(core_mem_wr),
        .core_mem_addr(core_mem_addr), .core_mem_wdata(core_mem_wdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_rst(core_rst), .core_halt(core_halt), .core_first_word(core_first_word),
        .halted(halted), .halt_word(halt_word), .halt_cycle(halt_cycle),
        .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // Monitor: every memory access and the first terminal status are checked against the queues
    always @(negedge clk) begin
        mem_t m_act, m_exp;
        st_t  s_act, s_exp;
        if (rst) begin
            term_seen = 1'b0;
        end else begin
            if (mem_en) begin
                assertions++;
                m_act = {mem_wr, mem_addr, mem_wdata};
                if (mem_q.size() == 0) begin
                    failures++;
                    $display("FAIL mem_unexpected: got %h, required no access", m_act);
                end else begin
                    m_exp = mem_q.pop_front();
                    if (m_act !== m_exp) begin
                        failures++;
                        $display("FAIL mem_access: got %h, required %h", m_act, m_exp);
                    end
                end
            end
            if (!term_seen && (done || err_code != 2'd0)) begin
                term_seen = 1'b1;
                assertions++;
                s_act = {done, core_rst, err_code, halted, halt_word, halt_cycle};
                if (st_q.size() == 0) begin
                    failures++;
                    $display("FAIL status_unexpected: got %h, required none", s_act);
                end else begin
                    s_exp = st_q.pop_front();
                    if (s_act !== s_exp) begin
                        failures++;
                        $display("FAIL status: got %h, required %h", s_act, s_exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertions++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_src_ready"}, 64'(src_ready), 64'd1);
        chk({tag, "_core_rst"}, 64'(core_rst), 64'd1);
        chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        chk({tag, "_status"}, 64'({halted, halt_word, halt_cycle, done, err_code}), 64'd0);
    endtask

    task automatic core_traffic(input bit expected);
        core_mem_req   = 1'($urandom_range(0, 1));
        core_mem_wr    = 1'($urandom_range(0, 1));
        core_mem_addr  = 16'($urandom);
        core_mem_wdata = 16'($urandom);
        if (core_mem_req && expected) begin
            mem_q.push_back({core_mem_wr, core_mem_addr, core_mem_wdata});
        end
    endtask

    task automatic pulse_reset();
        src_valid = 1'b0;
        core_mem_req = 1'b0;
        core_halt = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Boot: each offered word must land at the next address; core requests are noise
    task automatic do_load(input bit fixed);
        for (int i = 0; i < int'(LW); i++) begin
            int gaps;
            logic [15:0] w;
            gaps = fixed ? ((i == 2) ? 1 : 0) : int'($urandom_range(0, 2));
            w    = fixed ? 16'(16'h1111 * (i + 1)) : 16'($urandom);
            for (int g = 0; g < gaps; g++) begin
                src_valid = 1'b0;
                src_data  = 16'($urandom);
                core_traffic(1'b0);
                step();
            end
            src_valid = 1'b1;
            src_data  = w;
            core_traffic(1'b0);
            mem_q.push_back({1'b1, 16'(i), w});
            step();
        end
        src_valid = 1'b0;
        chk("release_core_rst", 64'(core_rst), 64'd1);
        chk("release_src_ready", 64'(src_ready), 64'd0);
        core_traffic(1'b0);
        step();
        chk("run_core_rst", 64'(core_rst), 64'd0);
    endtask

    // kind: 0 none, 1 halt drop, 2 word change, at settle edge k; rst_at: reset after that run edge
    task automatic scenario(input int h, input int kind, input int k, input logic [15:0] w,
                            input int rst_at, input bit fixed);
        int  t;
        bit  ok;
        st_t s;
        do_load(fixed);
        s = '0;
        ok = 1'b0;
        if (h == 0 || h > int'(TO) + 1) begin
            t = int'(TO) + 1;
            s.crst = 1'b1;
            s.err  = 2'd1;
        end else begin
            s.halted = 1'b1;
            s.word   = w;
            s.cyc    = CW'(h);
            if (kind != 0 && k <= int'(SC)) begin
                t = h + k;
                s.crst = 1'b1;
                s.err  = 2'(kind + 1);
            end else begin
                t = h + int'(SC);
                s.done = 1'b1;
                ok = 1'b1;
            end
        end
        if (rst_at == 0) st_q.push_back(s);
        for (int e = 1; e <= ((rst_at != 0) ? rst_at : t + 3); e++) begin
            core_halt = (h != 0 && e >= h && !(kind == 1 && e >= h + k));
            core_first_word = (h == 0 || e < h) ? 16'($urandom) :
                              (kind == 2 && e >= h + k) ? 16'(w + 16'd1) : w;
            core_traffic(e <= t || ok);
            step();
            if (rst_at == 0 && e == t - 1) chk("not_terminal_early", 64'(done || err_code != 2'd0), 64'd0);
            if (rst_at == 0 && e == t) chk("terminal_on_time", 64'(done || err_code != 2'd0), 64'd1);
        end
        core_mem_req = 1'b0;
        if (rst_at != 0) begin
            src_valid = 1'b0;
            core_mem_req = 1'b1;
            #1 rst = 1'b1;
            #1 check_reset_vals("midop_reset");
            core_mem_req = 1'b0;
            core_halt = 1'b0;
            step();
            rst = 1'b0;
        end else begin
            pulse_reset();
        end
    endtask

    initial begin
        #3 check_reset_vals("por");
        step();
        rst = 1'b0;
        scenario(37, 0, 0, 16'h00AB, 0, 1'b1);
        scenario(0, 0, 0, 16'h0000, 0, 1'b0);
        scenario(int'(TO) + 1, 0, 0, 16'h1234, 0, 1'b0);
        scenario(12, 1, 2, 16'h00AB, 0, 1'b0);
        scenario(15, 2, 3, 16'h00AB, 0, 1'b0);
        scenario(30, 0, 0, 16'h5555, 20, 1'b0);
        scenario(10, 0, 0, 16'h6666, 12, 1'b1);
        for (int r = 0; r < 12; r++) begin
            scenario(int'($urandom_range(1, TO + 4)), int'($urandom_range(0, 2)),
                     int'($urandom_range(1, SC + 2)), 16'($urandom), 0, 1'b0);
        end
        chk("mem_queue_drained", 64'(mem_q.size()), 64'd0);
        chk("status_queue_drained", 64'(st_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/boot_run_ctrl.md
# boot_run_ctrl

Hardware sequencer that boots and supervises the SoC core. After reset it streams a program image into main memory over a valid/ready source, arbitrating memory away from the core, then releases the core from reset and hands it the memory port. It then watches `core_halt`, snapshots the core's first word and the run-cycle count on the first halt, checks that the halt state stays stable for a settle window, and reports done or a coded error.

## Interface
- `LOAD_WORDS`, default 256. Number of words loaded at boot. Must be >= 1 and <= 2^16.
- `SETTLE_CYCLES`, default 5. Post-halt stability window, in cycles. Must be >= 1.
- `TIMEOUT`, default 1000. Maximum run cycles allowed before a halt.
- `CNT_W`, default 32. Width of the cycle counter.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `src_valid`  in  1  boot word available.
- `src_data`  in  16  boot word.
- `src_ready`  out  1  loader accepts the boot word.
- `core_mem_req`  in  1  core memory access request.
- `core_mem_wr`  in  1  core write (1) or read (0).
- `core_mem_addr`  in  16  core address.
- `core_mem_wdata`  in  16  core write data.
- `mem_en`  out  1  memory access enable.
- `mem_wr`  out  1  memory write enable.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  16  memory write data.
- `core_rst`  out  1  holds the core in reset while 1.
- `core_halt`  in  1  core halt indication.
- `core_first_word`  in  16  core's first-word observation value.
- `halted`  out  1  a halt has been captured.
- `halt_word`  out  16  `core_first_word` at the halt capture.
- `halt_cycle`  out  CNT_W  run-cycle count at the halt capture.
- `done`  out  1  successful completion.
- `err_code`  out  2  error code: 0 none, 1 timeout, 2 halt dropped, 3 word changed.

## Operation
- States are LOAD, RELEASE, RUN, SETTLE, DONE and ERROR. Reset enters LOAD.
- **LOAD**
  - `src_ready`=1 and `core_rst`=1.
  - Memory outputs are combinational from the loader: `mem_en`=`mem_wr`=`src_valid`, `mem_addr`=`load_addr`, `mem_wdata`=`src_data`.
  - Each edge with `src_valid`&`src_ready` increments `load_addr`.
  - The edge accepting word `LOAD_WORDS`-1 goes to RELEASE.
  - Core request inputs are ignored.
- **RELEASE** (one cycle)
  - `core_rst`=1, `src_ready`=0, memory outputs idle (all 0).
  - Clears `cycle_cnt` to 0, then goes to RUN.
- **RUN**
  - `core_rst`=0.
  - Memory outputs are combinational pass-through of the `core_mem_*` inputs (`mem_en`=`core_mem_req`). This passes through in RUN, SETTLE and DONE.
  - Each edge: `cycle_cnt` <= `cycle_cnt`+1.
  - If `core_halt`=1 on an edge:
    - `halted`<=1, `halt_word`<=`core_first_word`, `halt_cycle`<=`cycle_cnt`+1.
    - Settle counter cleared; go to SETTLE.
  - Else if `cycle_cnt`+1 > `TIMEOUT`: `err_code`<=1, go to ERROR.
  - A halt on the same edge has priority over the timeout.
- **SETTLE**
  - Each edge checks, in priority order:
    - `core_halt`=0: `err_code`<=2, go to ERROR.
    - `core_first_word`!=`halt_word`: `err_code`<=3, go to ERROR.
    - Otherwise the settle counter increments.
  - When the counter reaches `SETTLE_CYCLES`, go to DONE.
- **DONE**: `done`=1, terminal until reset. The core stays out of reset and stability checks stop.
- **ERROR**: `core_rst`=1, memory outputs idle, terminal until reset. `halted`, `halt_word` and `halt_cycle` keep their captured values.
- `cycle_cnt` wraps modulo 2^CNT_W. With legal parameters it cannot wrap before the timeout.

## Timing
- Reset values:
  - `src_ready`=1 (LOAD), `core_rst`=1.
  - `mem_en`/`mem_wr`=0 (while `src_valid`=0).
  - `halted`=0, `halt_word`=0, `halt_cycle`=0, `done`=0, `err_code`=0.
  - `load_addr`=0, `cycle_cnt`=0.
- Reset asserted mid-operation (any state) immediately forces LOAD and all reset values. It does not wait for a clock edge.
- Load throughput is 1 word/cycle. Boot takes `LOAD_WORDS` accepted beats, plus 1 RELEASE cycle, before `core_rst` falls.
- `core_rst` falls on the edge leaving RELEASE. The first RUN edge yields `cycle_cnt`=1.
- Halt capture registers update on the first edge where `core_halt` is sampled 1.
- `done` rises `SETTLE_CYCLES` edges after the capture edge.
- `src_ready` is not dependent on `src_valid` (no combinational loop).
- Memory outputs carry the same-cycle combinational path from `src_*`/`core_mem_*`.

## Test plan
- Boot: `LOAD_WORDS`=4, words 0x1111..0x4444 with a 1-cycle `src_valid` gap after word 2 -> writes to addresses 0..3 in order, no write during the gap. `core_rst` falls exactly 1 cycle after the 4th accept.
- Halt capture: core asserts `core_halt` with `core_first_word`=0x00AB on the 37th RUN edge and holds both -> `halted`=1, `halt_word`=0x00AB, `halt_cycle`=37, `done`=1 five edges later, `err_code`=0.
- Timeout: `TIMEOUT`=10, `core_halt` never asserted -> `err_code`=1 on the 11th RUN edge, `core_rst`=1, `done`=0. Halt on exactly the 11th edge -> captured, no error.
- Stability: halt captured, then `core_halt` drops 2 cycles later -> `err_code`=2. Separate run: word changes 0x00AB->0x00AC during SETTLE -> `err_code`=3.
- Arbitration: core drives `core_mem_req` during LOAD -> memory sees only loader traffic. In RUN, a core write to 0x0100 of 0xBEEF appears on `mem_*` in the same cycle.
- Reset mid-RUN and mid-SETTLE -> all outputs at reset values immediately. The next boot restarts at address 0.
